hack_fetch_unit: RTL and testbench

- Instruction fetch stage of the Hack CPU; sits directly upstream of the instruction register.
- Owns the program counter and issues one read at a time to instruction ROM, which has variable latency.
- Delivers each fetched 16-bit word with a one-cycle valid pulse.
- Supports stall from downstream and jump redirect from the ALU/branch logic, with squashing of in-flight fetches.

---
 rtl/hack_fetch_pkg.sv | 13 +
 rtl/hack_pc_counter.sv | 31 +++
 rtl/hack_fetch_unit.sv | 132 +++++++++++++
 tb/tb_hack_fetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_fetch_pkg.sv
// Shared defaults and state encoding for the Hack CPU instruction fetch stage.
package hack_fetch_pkg;

  localparam int unsigned DEFAULT_ADDR_W   = 15;
  localparam int unsigned DEFAULT_DATA_W   = 16;
  localparam int unsigned DEFAULT_RESET_PC = 0;

  typedef enum logic {
    StIssue = 1'b0,
    StWait  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/hack_pc_counter.sv
// Program counter register: synchronous reset, jump load, modulo increment.
module hack_pc_counter
  import hack_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_q;

  // Load wins over increment; the add wraps naturally at ADDR_W bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= ADDR_W'(RESET_PC);
    end else if (load) begin
      pc_q <= load_addr;
    end else if (inc) begin
      pc_q <= pc_q + ADDR_W'(1);
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/hack_fetch_unit.sv
// Hack CPU fetch stage: one outstanding ROM read, stall, jump redirect with squash.
// Optional performance counters when HACK_FETCH_PERF_EN is defined.
module hack_fetch_unit
  import hack_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W   = DEFAULT_DATA_W,
  parameter int unsigned RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic              rom_req,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rdata,
  input  logic              rom_valid,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] fetch_pc
`ifdef HACK_FETCH_PERF_EN
  ,
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_squashed
`endif
);

  fetch_state_t      state_q, state_d;
  logic              flush_q, flush_d;
  logic [DATA_W-1:0] instr_q;
  logic              valid_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] pc;
  logic              pc_load, pc_inc;
  logic              deliver, squash;

  hack_pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk       (clk),
    .reset     (reset),
    .load      (pc_load),
    .inc       (pc_inc),
    .load_addr (jump_addr),
    .pc        (pc)
  );

  // Gated by reset so no request escapes while the stage is being cleared.
  assign rom_req  = (state_q == StIssue) && !stall && !jump_en && !reset;
  assign rom_addr = pc;

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    deliver = 1'b0;
    squash  = 1'b0;
    unique case (state_q)
      StIssue: begin
        if (jump_en) begin
          pc_load = 1'b1;
        end else if (rom_req) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (rom_valid) begin
          state_d = StIssue;
          if (flush_q || jump_en) begin
            squash  = 1'b1;
            flush_d = 1'b0;
            pc_load = jump_en;
          end else begin
            deliver = 1'b1;
            pc_inc  = 1'b1;
          end
        end else if (jump_en) begin
          pc_load = 1'b1;
          flush_d = 1'b1;
        end
      end
      default: state_d = StIssue;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIssue;
      flush_q    <= 1'b0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      fetch_pc_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      valid_q <= deliver;
      if (deliver) begin
        instr_q    <= rom_rdata;
        fetch_pc_q <= pc;
      end
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign fetch_pc    = fetch_pc_q;

`ifdef HACK_FETCH_PERF_EN
  logic [15:0] fetched_q, squashed_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q  <= '0;
      squashed_q <= '0;
    end else begin
      if (valid_q && (fetched_q != 16'hFFFF)) begin
        fetched_q <= fetched_q + 16'd1;
      end
      if (squash && (squashed_q != 16'hFFFF)) begin
        squashed_q <= squashed_q + 16'd1;
      end
    end
  end

  assign perf_fetched  = fetched_q;
  assign perf_squashed = squashed_q;
`endif

endmodule

// File: tb/tb_hack_fetch_unit.sv
// Directed self-checking bench for hack_fetch_unit; scenarios run back to back on one timeline.
module tb_hack_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        jump_en;
  logic [14:0] jump_addr;
  logic        rom_req;
  logic [14:0] rom_addr;
  logic [15:0] rom_rdata;
  logic        rom_valid;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic [14:0] fetch_pc;
`ifdef HACK_FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_squashed;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hack_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .jump_en     (jump_en),
    .jump_addr   (jump_addr),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_rdata   (rom_rdata),
    .rom_valid   (rom_valid),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .fetch_pc    (fetch_pc)
`ifdef HACK_FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_squashed (perf_squashed)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; jump_en = 1'b0; jump_addr = '0;
    rom_valid = 1'b0; rom_rdata = '0;
    step();
    step();
    #2;
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== 16'h0 || fetch_pc !== 15'h0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%b instr=%h pc=%h, want 0 0000 0000",
               instr_valid, instr_out, fetch_pc);
    end
    checks++;
    if (rom_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_req: rom_req=%b, want 0", rom_req);
    end
`ifdef HACK_FETCH_PERF_EN
    checks++;
    if (perf_fetched !== 16'h0 || perf_squashed !== 16'h0) begin
      failures++;
      $display("FAIL reset_perf: fetched=%h squashed=%h, want 0 0", perf_fetched, perf_squashed);
    end
`endif
  endtask

  // 1-cycle ROM latency: addresses 0,1,2 with data 0x1000+addr, one word every 2 cycles.
  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      step();
      reset = 1'b0; rom_valid = 1'b0;
      #2;
      checks++;
      if (rom_req !== 1'b1 || rom_addr !== 15'(i)) begin
        failures++;
        $display("FAIL seq_req%0d: req=%b addr=%h, want 1 %h", i, rom_req, rom_addr, 15'(i));
      end
      if (i > 0) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_out !== 16'h1000 + 16'(i - 1)
            || fetch_pc !== 15'(i - 1)) begin
          failures++;
          $display("FAIL seq_data%0d: valid=%b instr=%h pc=%h, want 1 %h %h", i - 1,
                   instr_valid, instr_out, fetch_pc, 16'h1000 + 16'(i - 1), 15'(i - 1));
        end
      end
      step();
      rom_valid = 1'b1; rom_rdata = 16'h1000 + 16'(i);
      #2;
      checks++;
      if (rom_req !== 1'b0 || instr_valid !== 1'b0) begin
        failures++;
        $display("FAIL seq_wait%0d: req=%b valid=%b, want 0 0", i, rom_req, instr_valid);
      end
    end
    // Last delivery; stall goes high here so the stage parks in ISSUE at pc=3.
    step();
    rom_valid = 1'b0; stall = 1'b1;
    #2;
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== 16'h1002 || fetch_pc !== 15'h2) begin
      failures++;
      $display("FAIL seq_data2: valid=%b instr=%h pc=%h, want 1 1002 0002",
               instr_valid, instr_out, fetch_pc);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    checks++;
    if (rom_req !== 1'b0) begin
      failures++;
      $display("FAIL stall_c0: rom_req=%b, want 0", rom_req);
    end
    for (int i = 1; i < 5; i++) begin
      step();
      #2;
      if (rom_req !== 1'b0 || instr_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL stall_hold: %0d stalled cycles showed req or valid, want 0", bad);
    end
    step();
    stall = 1'b0;
    #2;
    checks++;
    if (rom_req !== 1'b1 || rom_addr !== 15'h3) begin
      failures++;
      $display("FAIL stall_release: req=%b addr=%h, want 1 0003", rom_req, rom_addr);
    end
    // Deliver 3 and 4, then leave a request for 5 in flight.
    for (int a = 3; a < 5; a++) begin
      step();
      rom_valid = 1'b1; rom_rdata = 16'h1000 + 16'(a);
      step();
      rom_valid = 1'b0;
      #2;
      checks++;
      if (instr_valid !== 1'b1 || fetch_pc !== 15'(a) || rom_req !== 1'b1
          || rom_addr !== 15'(a + 1)) begin
        failures++;
        $display("FAIL stall_after%0d: valid=%b pc=%h req=%b addr=%h, want 1 %h 1 %h", a,
                 instr_valid, fetch_pc, rom_req, rom_addr, 15'(a), 15'(a + 1));
      end
    end
  endtask

  task automatic test_squash();
    step();
    jump_en = 1'b1; jump_addr = 15'h0100;
    step();
    jump_en = 1'b0;
    step();
    rom_valid = 1'b1; rom_rdata = 16'hDEAD;
    #2;
    checks++;
    if (instr_valid !== 1'b0 || rom_req !== 1'b0) begin
      failures++;
      $display("FAIL squash_wait: valid=%b req=%b, want 0 0", instr_valid, rom_req);
    end
    step();
    rom_valid = 1'b0;
    #2;
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== 16'h1004) begin
      failures++;
      $display("FAIL squash_drop: valid=%b instr=%h, want 0 1004", instr_valid, instr_out);
    end
    checks++;
    if (rom_req !== 1'b1 || rom_addr !== 15'h0100) begin
      failures++;
      $display("FAIL squash_redirect: req=%b addr=%h, want 1 0100", rom_req, rom_addr);
    end
    step();
    rom_valid = 1'b1; rom_rdata = 16'h2100;
    step();
    rom_valid = 1'b0;
    #2;
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== 16'h2100 || fetch_pc !== 15'h0100) begin
      failures++;
      $display("FAIL squash_next: valid=%b instr=%h pc=%h, want 1 2100 0100",
               instr_valid, instr_out, fetch_pc);
    end
  endtask

  task automatic test_jump_with_valid();
    step();
    rom_valid = 1'b1; rom_rdata = 16'hBEEF; jump_en = 1'b1; jump_addr = 15'h0020;
    step();
    rom_valid = 1'b0; jump_en = 1'b0;
    #2;
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== 16'h2100 || rom_req !== 1'b1
        || rom_addr !== 15'h0020) begin
      failures++;
      $display("FAIL jump_valid: valid=%b instr=%h req=%b addr=%h, want 0 2100 1 0020",
               instr_valid, instr_out, rom_req, rom_addr);
    end
    step();
    rom_valid = 1'b1; rom_rdata = 16'h3020;
    // Delivery cycle doubles as an ISSUE-state jump to the top of memory.
    step();
    rom_valid = 1'b0; jump_en = 1'b1; jump_addr = 15'h7FFF;
    #2;
    checks++;
    if (instr_valid !== 1'b1 || fetch_pc !== 15'h0020 || rom_req !== 1'b0) begin
      failures++;
      $display("FAIL jump_issue: valid=%b pc=%h req=%b, want 1 0020 0",
               instr_valid, fetch_pc, rom_req);
    end
  endtask

  task automatic test_wrap();
    step();
    jump_en = 1'b0;
    #2;
    checks++;
    if (rom_req !== 1'b1 || rom_addr !== 15'h7FFF) begin
      failures++;
      $display("FAIL wrap_req: req=%b addr=%h, want 1 7fff", rom_req, rom_addr);
    end
    step();
    rom_valid = 1'b1; rom_rdata = 16'h7777;
    step();
    rom_valid = 1'b0;
    #2;
    checks++;
    if (instr_valid !== 1'b1 || instr_out !== 16'h7777 || fetch_pc !== 15'h7FFF) begin
      failures++;
      $display("FAIL wrap_data: valid=%b instr=%h pc=%h, want 1 7777 7fff",
               instr_valid, instr_out, fetch_pc);
    end
    checks++;
    if (rom_req !== 1'b1 || rom_addr !== 15'h0000) begin
      failures++;
      $display("FAIL wrap_next: req=%b addr=%h, want 1 0000", rom_req, rom_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    step();
    reset = 1'b1;
    #2;
    checks++;
    if (rom_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_req: rom_req=%b during reset, want 0", rom_req);
    end
    step();
    reset = 1'b0; rom_valid = 1'b1; rom_rdata = 16'h5555;
    #2;
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== 16'h0 || fetch_pc !== 15'h0) begin
      failures++;
      $display("FAIL rst_clear: valid=%b instr=%h pc=%h, want 0 0000 0000",
               instr_valid, instr_out, fetch_pc);
    end
    checks++;
    if (rom_req !== 1'b1 || rom_addr !== 15'h0) begin
      failures++;
      $display("FAIL rst_pc: req=%b addr=%h, want 1 0000", rom_req, rom_addr);
    end
    step();
    rom_valid = 1'b0;
    #2;
    checks++;
    if (instr_valid !== 1'b0 || instr_out !== 16'h0) begin
      failures++;
      $display("FAIL rst_stale: valid=%b instr=%h, want 0 0000", instr_valid, instr_out);
    end
`ifdef HACK_FETCH_PERF_EN
    checks++;
    if (perf_fetched !== 16'h0 || perf_squashed !== 16'h0) begin
      failures++;
      $display("FAIL rst_perf: fetched=%h squashed=%h, want 0 0", perf_fetched, perf_squashed);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_squash();
    test_jump_with_valid();
    test_wrap();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
